// File: rtl/sobel_pkg.sv
// Shared constants, framing bundle and gradient helper for the Sobel edge stage.
package sobel_pkg;

  localparam int DEF_COLORDEPTH = 8;
  localparam int SOB_LAT        = 4;
  localparam int GRAD_W         = 11;
  localparam int MAG_W          = 12;
  localparam int MAG_MAX        = 255;
  localparam int CNT_W          = 11;
  localparam int ROW_MAX        = 2047;

  typedef struct packed {
    logic dv;
    logic hs;
    logic vs;
    logic line_end;
  } sync_t;

  function automatic logic [MAG_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    logic signed [GRAD_W-1:0] m;
    m = g[GRAD_W-1] ? -g : g;
    return MAG_W'($unsigned(m));
  endfunction

endpackage

// File: rtl/sobel_3x3_line_ram.sv
// Simple dual-port line buffer with one-cycle registered read; read-before-write on a shared address.
module line_ram #(
  parameter int DEPTH = 1600,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; stale lines are masked downstream.
  // NOTE: non-blocking updates make a same-address read return the pre-write word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sobel_3x3.sv
// Streaming 3x3 Sobel magnitude with two line buffers, fixed four-cycle latency and optional binarisation.
module sobel_3x3
  import sobel_pkg::*;
#(
  parameter int COLORDEPTH  = DEF_COLORDEPTH,
  parameter int SCREENWIDTH = 1600
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COLORDEPTH-1:0] data_i,
  input  logic                  dv_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  input  logic                  line_end_i,
  input  logic [7:0]            thr_i,
  output logic [COLORDEPTH-1:0] sob_o,
  output logic                  dv_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  line_end_o
);

  localparam int AW = $clog2(SCREENWIDTH);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(SCREENWIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROW_MAX);
  localparam int S3 = SOB_LAT - 2;

  function automatic logic signed [GRAD_W-1:0] gext(input logic [COLORDEPTH-1:0] p);
    return signed'(GRAD_W'(p));
  endfunction

  logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
  logic             col_ovf_q, col_ovf_d;
  logic             vs_prev_q, frame_ok_q, frame_ok_d;
  logic [7:0]       thr_q, thr_d;
  logic             vs_rise, l1_we;

  sync_t [SOB_LAT-1:0] sync_pipe_q, sync_pipe_d;
  logic  [S3:0]        inner_q, inner_d;

  logic [COLORDEPTH-1:0] data_s1_q, data_s1_d;
  logic [AW-1:0]         col_s1_q, col_s1_d;
  logic                  l2_we_q, l2_we_d;
  logic [COLORDEPTH-1:0] l1_rd, l2_rd;

  logic [2:0][2:0][COLORDEPTH-1:0] win_q, win_d;
  logic signed [GRAD_W-1:0]        gx_q, gx_d, gy_q, gy_d;
  logic [MAG_W-1:0]                mag;
  logic [COLORDEPTH-1:0]           sob_q, sob_d;

  assign l1_we = dv_i & ~col_ovf_q;

  // L1 holds the previous line; L2 receives L1's displaced word one cycle later.
  line_ram #(.DEPTH(SCREENWIDTH), .WIDTH(COLORDEPTH)) u_l1 (
    .clk(clk), .we(l1_we), .waddr(col_q[AW-1:0]), .wdata(data_i),
    .re(dv_i), .raddr(col_q[AW-1:0]), .rdata(l1_rd)
  );

  line_ram #(.DEPTH(SCREENWIDTH), .WIDTH(COLORDEPTH)) u_l2 (
    .clk(clk), .we(l2_we_q), .waddr(col_s1_q), .wdata(l1_rd),
    .re(dv_i), .raddr(col_q[AW-1:0]), .rdata(l2_rd)
  );

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    vs_rise   = vs_i & ~vs_prev_q;
    col_d     = col_q;
    col_ovf_d = col_ovf_q;
    if (line_end_i) begin
      col_d     = '0;
      col_ovf_d = 1'b0;
    end else if (dv_i) begin
      if (col_q == COL_LAST) col_ovf_d = 1'b1;
      else                   col_d     = col_q + 1'b1;
    end

    row_d = row_q;
    if (vs_rise)                              row_d = '0;
    else if (line_end_i && row_q != ROW_LAST) row_d = row_q + 1'b1;

    thr_d       = vs_rise ? thr_i : thr_q;
    frame_ok_d  = frame_ok_q | vs_rise;
    sync_pipe_d = {sync_pipe_q[SOB_LAT-2:0], sync_t'{dv_i, hs_i, vs_i, line_end_i}};
    inner_d     = {inner_q[S3-1:0],
                   frame_ok_q && (row_q >= CNT_W'(2)) && (col_q >= CNT_W'(2))};
    data_s1_d   = data_i;
    col_s1_d    = col_q[AW-1:0];
    l2_we_d     = l1_we;

    win_d = win_q;
    if (sync_pipe_q[0].dv) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = l2_rd;
      win_d[1][2] = l1_rd;
      win_d[2][2] = data_s1_q;
    end

    gx_d = (gext(win_q[0][2]) + (gext(win_q[1][2]) <<< 1) + gext(win_q[2][2]))
         - (gext(win_q[0][0]) + (gext(win_q[1][0]) <<< 1) + gext(win_q[2][0]));
    gy_d = (gext(win_q[2][0]) + (gext(win_q[2][1]) <<< 1) + gext(win_q[2][2]))
         - (gext(win_q[0][0]) + (gext(win_q[0][1]) <<< 1) + gext(win_q[0][2]));

    mag   = abs_grad(gx_q) + abs_grad(gy_q);
    sob_d = '0;
    if (sync_pipe_q[S3].dv && inner_q[S3]) begin
      if (thr_q == '0)
        sob_d = (mag > MAG_W'(MAG_MAX)) ? COLORDEPTH'(MAG_MAX) : mag[COLORDEPTH-1:0];
      else
        sob_d = (mag >= MAG_W'(thr_q)) ? COLORDEPTH'(MAG_MAX) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      col_ovf_q   <= 1'b0;
      row_q       <= '0;
      vs_prev_q   <= 1'b0;
      frame_ok_q  <= 1'b0;
      thr_q       <= '0;
      sync_pipe_q <= '0;
      inner_q     <= '0;
      data_s1_q   <= '0;
      col_s1_q    <= '0;
      l2_we_q     <= 1'b0;
      win_q       <= '0;
      gx_q        <= '0;
      gy_q        <= '0;
      sob_q       <= '0;
    end else begin
      col_q       <= col_d;
      col_ovf_q   <= col_ovf_d;
      row_q       <= row_d;
      vs_prev_q   <= vs_i;
      frame_ok_q  <= frame_ok_d;
      thr_q       <= thr_d;
      sync_pipe_q <= sync_pipe_d;
      inner_q     <= inner_d;
      data_s1_q   <= data_s1_d;
      col_s1_q    <= col_s1_d;
      l2_we_q     <= l2_we_d;
      win_q       <= win_d;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      sob_q       <= sob_d;
    end
  end

  assign sob_o      = sob_q;
  assign dv_o       = sync_pipe_q[SOB_LAT-1].dv;
  assign hs_o       = sync_pipe_q[SOB_LAT-1].hs;
  assign vs_o       = sync_pipe_q[SOB_LAT-1].vs;
  assign line_end_o = sync_pipe_q[SOB_LAT-1].line_end;

endmodule

// File: tb/tb_sobel_3x3.sv
// Self-checking bench: image-array reference model of the Sobel stage, compared every cycle at the output.
module tb_sobel_3x3;

  localparam int CD   = 8;
  localparam int SW   = 32;
  localparam int W    = 24;
  localparam int MAXR = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CD-1:0] data_i = '0;
  logic          dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0, line_end_i = 1'b0;
  logic [7:0]    thr_i = '0;
  logic [CD-1:0] sob_o;
  logic          dv_o, hs_o, vs_o, line_end_o;

  always #5 clk = ~clk;

  sobel_3x3 #(.COLORDEPTH(CD), .SCREENWIDTH(SW)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .line_end_i(line_end_i), .thr_i(thr_i), .sob_o(sob_o), .dv_o(dv_o), .hs_o(hs_o),
    .vs_o(vs_o), .line_end_o(line_end_o)
  );

  int total = 0;
  int bad   = 0;
  int nz_cnt, nz_sum;

  // Reference state: pixel image indexed by frame coordinates, plus framing bookkeeping.
  int   img [MAXR][SW];
  int   m_row = 0, m_col = 0, m_thr = 0;
  bit   m_ovf = 1'b0, m_vsp = 1'b0, m_framed = 1'b0;
  logic [11:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [11:0] model(input bit r, input bit dv, input bit hs, input bit vs,
                                        input bit le, input logic [7:0] d);
    int   sob, gx, gy, mag, wt;
    bit   vs_rise;
    logic [7:0] s8;
    if (r) begin
      m_row = 0; m_col = 0; m_ovf = 1'b0; m_vsp = 1'b0; m_framed = 1'b0; m_thr = 0;
      return '0;
    end
    vs_rise = vs && !m_vsp;
    sob = 0;
    if (dv) begin
      if (!m_ovf && m_row < MAXR) img[m_row][m_col] = int'(d);
      if (m_framed && m_row >= 2 && m_col >= 2 && m_row < MAXR) begin
        gx = 0;
        gy = 0;
        for (int i = 0; i < 3; i++) begin
          wt = (i == 1) ? 2 : 1;
          gx += wt * (img[m_row-2+i][m_col] - img[m_row-2+i][m_col-2]);
          gy += wt * (img[m_row][m_col-2+i] - img[m_row-2][m_col-2+i]);
        end
        mag = iabs(gx) + iabs(gy);
        if (m_thr == 0) sob = (mag > 255) ? 255 : mag;
        else            sob = (mag >= m_thr) ? 255 : 0;
      end
    end
    if (le) begin
      m_col = 0;
      m_ovf = 1'b0;
    end else if (dv) begin
      if (m_col == SW - 1) m_ovf = 1'b1;
      else                 m_col++;
    end
    if (vs_rise) m_row = 0;
    else if (le && m_row < 2047) m_row++;
    if (vs_rise) begin
      m_thr    = int'(thr_i);
      m_framed = 1'b1;
    end
    m_vsp = vs;
    s8 = sob[7:0];
    return {dv, hs, vs, le, s8};
  endfunction

  // One clock: compare the output for the input driven four steps ago, then drive the next input.
  task automatic step(input bit r, input bit dv, input bit hs, input bit vs, input bit le,
                      input logic [7:0] d);
    logic [11:0] e;
    @(negedge clk);
    if (exp_q.size() == 4) begin
      e = exp_q.pop_front();
      check("out", {dv_o, hs_o, vs_o, line_end_o, sob_o}, e);
      if (dv_o && sob_o != 0) begin
        nz_cnt++;
        nz_sum += int'(sob_o);
      end
    end
    if (r) begin
      for (int i = 0; i < exp_q.size(); i++) exp_q[i] = '0;
    end
    rst = r; dv_i = dv; hs_i = hs; vs_i = vs; line_end_i = le; data_i = d;
    exp_q.push_back(model(r, dv, hs, vs, le, d));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  function automatic logic [7:0] pix(input int pat, input int c);
    case (pat)
      0:       return 8'd100;
      1:       return (c < 20) ? 8'd0 : 8'd100;
      2:       return 8'(c);
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // gap_mode: 0 none, 1 two idle cycles before each pixel, 2 random 0..2 idle cycles.
  task automatic frame(input int pat, input int h, input int gap_mode, input int thr,
                       input int rst_row, input int thr_mid);
    thr_i = 8'(thr);
    nz_cnt = 0;
    nz_sum = 0;
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    idle(3);
    for (int r = 0; r < h; r++) begin
      if (r == rst_row) begin
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        nz_cnt = 0;
        nz_sum = 0;
      end
      if (r == h / 2 && thr_mid >= 0) thr_i = 8'(thr_mid);
      repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
      idle(2);
      for (int c = 0; c < W; c++) begin
        if (gap_mode == 1)      idle(2);
        else if (gap_mode == 2) idle(int'($urandom_range(0, 2)));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pix(pat, c));
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
      idle(4);
    end
    idle(6);
  endtask

  initial begin
    int t;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    idle(5);
    check("rst_sob", {24'd0, sob_o}, 0);
    check("rst_sync", {dv_o, hs_o, vs_o, line_end_o}, 0);

    frame(0, 6, 0, 0, -1, -1);
    check("flat_nz", nz_cnt, 0);

    frame(1, 6, 0, 0, -1, -1);
    check("step_nz", nz_cnt, 8);
    check("step_sum", nz_sum, 8 * 255);

    frame(2, 6, 0, 0, -1, -1);
    check("ramp_nz", nz_cnt, 4 * 22);
    check("ramp_sum", nz_sum, 4 * 22 * 8);

    frame(2, 6, 0, 8, -1, 9);
    check("thr8_nz", nz_cnt, 4 * 22);
    check("thr8_sum", nz_sum, 4 * 22 * 255);

    frame(2, 6, 0, 9, -1, -1);
    check("thr9_nz", nz_cnt, 0);

    frame(1, 6, 1, 0, -1, -1);
    check("gap_nz", nz_cnt, 8);
    check("gap_sum", nz_sum, 8 * 255);

    for (int k = 0; k < 4; k++) begin
      t = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 255));
      frame(3, 6, 2, t, -1, -1);
    end

    frame(3, 54, 0, 0, 50, -1);
    check("rst_mid_nz", nz_cnt, 0);

    frame(3, 6, 2, 0, -1, -1);
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
